lc4_rob: RTL and testbench

- 4-entry in-order reorder buffer for the LC4 out-of-order core.
- Allocates entries at dispatch and hands back the ROB index that travels down the pipeline latches.
- Marks entries complete when the writeback latch delivers valid/rob_index/exec results.
- Retires completed entries strictly in program order, and squashes everything on a committed mispredict.

---
 rtl/lc4_rob_if.sv | 61 ++++++
 rtl/lc4_rob.sv | 148 ++++++++++++++
 tb/tb_lc4_rob.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc4_rob_if.sv
// ============================================================================
//  Module      : lc4_rob_if
//  Description : Bundles the reorder buffer's dispatch, writeback and commit
//                signals. The master side is the pipeline (dispatch and the
//                writeback latch). The slave side is the ROB.
//  Ports       : alloc_* (dispatch request and returned index)
//                wb_*    (writeback latch results)
//                commit_*, flush, flush_pc, count (retirement view)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lc4_rob_if #(
  parameter int IDX_W  = 2,
  parameter int PREG_W = 4
);
  // dispatch
  logic              alloc_valid;
  logic [15:0]       alloc_pc;
  logic [15:0]       alloc_insn;
  logic              alloc_has_rd;
  logic [PREG_W-1:0] alloc_prd;
  logic [PREG_W-1:0] alloc_old_prd;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_index;
  // writeback
  logic              wb_valid;
  logic [IDX_W-1:0]  wb_index;
  logic [15:0]       wb_result;
  logic              wb_mispredict;
  logic [15:0]       wb_pc_redirect;
  // commit
  logic              commit_valid;
  logic [15:0]       commit_pc;
  logic [15:0]       commit_insn;
  logic              commit_has_rd;
  logic [PREG_W-1:0] commit_prd;
  logic [PREG_W-1:0] commit_old_prd;
  logic [15:0]       commit_result;
  logic              flush;
  logic [15:0]       flush_pc;
  logic [IDX_W:0]    count;

  modport master (
    output alloc_valid, alloc_pc, alloc_insn, alloc_has_rd, alloc_prd, alloc_old_prd,
    output wb_valid, wb_index, wb_result, wb_mispredict, wb_pc_redirect,
    input  alloc_ready, alloc_index,
    input  commit_valid, commit_pc, commit_insn, commit_has_rd, commit_prd,
    input  commit_old_prd, commit_result, flush, flush_pc, count
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_insn, alloc_has_rd, alloc_prd, alloc_old_prd,
    input  wb_valid, wb_index, wb_result, wb_mispredict, wb_pc_redirect,
    output alloc_ready, alloc_index,
    output commit_valid, commit_pc, commit_insn, commit_has_rd, commit_prd,
    output commit_old_prd, commit_result, flush, flush_pc, count
  );
endinterface

`default_nettype wire

// File: rtl/lc4_rob.sv
// ============================================================================
//  Module      : lc4_rob
//  Description : In-order reorder buffer for the LC4 out-of-order core.
//                Dispatch allocates at the tail, the writeback latch marks
//                entries done, and the head retires in program order. A
//                committing mispredict retires the head and squashes the
//                rest of the buffer.
//  Ports       : clk   - core clock, rising edge
//                rst_n - asynchronous active-low reset
//                gwe   - global write enable; no state change when low
//                bus   - lc4_rob_if.slave (alloc_*, wb_*, commit_*, flush*, count)
//  Options     : LC4_ROB_BYPASS_EN - lets a full ROB accept a dispatch in the
//                same cycle that its head commits.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lc4_rob #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = 2,
  parameter int PREG_W  = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  input  wire logic   gwe,
  lc4_rob_if.slave    bus
);

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(ENTRIES);

  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [IDX_W:0]    cnt;

  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] done;
  logic [ENTRIES-1:0] misp;
  logic [ENTRIES-1:0] has_rd_q;
  logic [15:0]        pc_q       [ENTRIES];
  logic [15:0]        insn_q     [ENTRIES];
  logic [15:0]        result_q   [ENTRIES];
  logic [15:0]        redirect_q [ENTRIES];
  logic [PREG_W-1:0]  prd_q      [ENTRIES];
  logic [PREG_W-1:0]  old_prd_q  [ENTRIES];

  logic commit_ok;
  logic flush_ok;
  logic alloc_ok;
  logic commit_fire;
  logic flush_fire;
  logic alloc_fire;
  logic wb_fire;

  always_comb begin
    commit_ok   = busy[head] & done[head];
    flush_ok    = commit_ok & misp[head];
`ifdef LC4_ROB_BYPASS_EN
    // The slot freed by this cycle's commit can be handed straight back out.
    alloc_ok    = (cnt < FULL) | (commit_ok & ~flush_ok);
`else
    alloc_ok    = (cnt < FULL);
`endif
    commit_fire = commit_ok & gwe;
    flush_fire  = flush_ok & gwe;
    // A squash drops the same-cycle dispatch; the writeback is moot because
    // every entry is cleared anyway.
    alloc_fire  = bus.alloc_valid & alloc_ok & gwe & ~flush_ok;
    wb_fire     = bus.wb_valid & gwe & busy[bus.wb_index];
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush_fire) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (commit_fire) head <= head + 1'b1;
      if (alloc_fire)  tail <= tail + 1'b1;
      case ({alloc_fire, commit_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage. Later statements win, so an allocation into the slot being
  // retired this cycle (bypass case) leaves it busy with the new insn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      done     <= '0;
      misp     <= '0;
      has_rd_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        pc_q[i]       <= '0;
        insn_q[i]     <= '0;
        result_q[i]   <= '0;
        redirect_q[i] <= '0;
        prd_q[i]      <= '0;
        old_prd_q[i]  <= '0;
      end
    end else if (flush_fire) begin
      busy <= '0;
      done <= '0;
      misp <= '0;
    end else begin
      if (commit_fire) busy[head] <= 1'b0;
      if (wb_fire) begin
        done[bus.wb_index]       <= 1'b1;
        misp[bus.wb_index]       <= bus.wb_mispredict;
        result_q[bus.wb_index]   <= bus.wb_result;
        redirect_q[bus.wb_index] <= bus.wb_pc_redirect;
      end
      if (alloc_fire) begin
        busy[tail]      <= 1'b1;
        done[tail]      <= 1'b0;
        misp[tail]      <= 1'b0;
        pc_q[tail]      <= bus.alloc_pc;
        insn_q[tail]    <= bus.alloc_insn;
        has_rd_q[tail]  <= bus.alloc_has_rd;
        prd_q[tail]     <= bus.alloc_prd;
        old_prd_q[tail] <= bus.alloc_old_prd;
      end
    end
  end

  assign bus.alloc_ready    = alloc_ok;
  assign bus.alloc_index    = tail;
  assign bus.commit_valid   = commit_ok;
  assign bus.commit_pc      = pc_q[head];
  assign bus.commit_insn    = insn_q[head];
  assign bus.commit_has_rd  = has_rd_q[head];
  assign bus.commit_prd     = prd_q[head];
  assign bus.commit_old_prd = old_prd_q[head];
  assign bus.commit_result  = result_q[head];
  assign bus.flush          = flush_ok;
  assign bus.flush_pc       = flush_ok ? redirect_q[head] : 16'h0000;
  assign bus.count          = cnt;

endmodule

`default_nettype wire

// File: tb/tb_lc4_rob.sv
// ============================================================================
//  Module      : tb_lc4_rob
//  Description : Self-checking bench for lc4_rob. Directed scenarios plus a
//                randomized run compared against a program-order queue model.
//                Define LC4_ROB_BYPASS_EN to check the bypass build.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lc4_rob;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gwe = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  lc4_rob_if #(.IDX_W(2), .PREG_W(4)) bus ();

  lc4_rob #(.ENTRIES(4), .IDX_W(2), .PREG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gwe   (gwe),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] pc;
    logic [15:0] insn;
    logic        has_rd;
    logic [3:0]  prd;
    logic [3:0]  oprd;
    logic        done;
    logic        misp;
    logic [15:0] res;
    logic [15:0] red;
  } ent_t;

  // One clock: apply inputs now (at a falling edge), return at the next
  // falling edge. The insn payload is derived from the pc so the model can
  // recompute it.
  task automatic cyc(input logic av, input logic [15:0] pc, input logic wv,
                     input logic [1:0] widx, input logic [15:0] wres,
                     input logic wmis, input logic [15:0] wred, input logic g);
    bus.alloc_valid    = av;
    bus.alloc_pc       = pc;
    bus.alloc_insn     = pc ^ 16'h5A00;
    bus.alloc_has_rd   = pc[0];
    bus.alloc_prd      = pc[3:0];
    bus.alloc_old_prd  = pc[7:4];
    bus.wb_valid       = wv;
    bus.wb_index       = widx;
    bus.wb_result      = wres;
    bus.wb_mispredict  = wmis;
    bus.wb_pc_redirect = wred;
    gwe                = g;
    @(posedge clk);
    @(negedge clk);
    bus.alloc_valid = 1'b0;
    bus.wb_valid    = 1'b0;
    gwe             = 1'b1;
  endtask

  task automatic alloc(input logic [15:0] pc);
    cyc(1'b1, pc, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic wb(input logic [1:0] idx, input logic [15:0] res);
    cyc(1'b0, 16'h0, 1'b1, idx, res, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.wb_valid    = 1'b0;
    gwe             = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    tests++; if (bus.alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", bus.alloc_ready); end
    tests++; if (bus.alloc_index !== 2'd0) begin fails++; $display("FAIL reset_index: got %0d expected 0", bus.alloc_index); end
    tests++; if ({bus.commit_valid, bus.flush, bus.flush_pc} !== 18'h0) begin fails++; $display("FAIL reset_commit_flush: got %h expected 0", {bus.commit_valid, bus.flush, bus.flush_pc}); end
    tests++; if ({bus.commit_pc, bus.commit_insn, bus.commit_result, bus.commit_has_rd, bus.commit_prd, bus.commit_old_prd} !== 57'h0) begin
      fails++; $display("FAIL reset_payload: got %h expected 0", {bus.commit_pc, bus.commit_insn, bus.commit_result, bus.commit_has_rd, bus.commit_prd, bus.commit_old_prd});
    end
  endtask

  // Fill, overflow attempt, out-of-order writeback, in-order retirement.
  task automatic test_fill_inorder();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tests++; if (bus.alloc_index !== 2'(i)) begin fails++; $display("FAIL fill_index: got %0d expected %0d", bus.alloc_index, i); end
      alloc(16'(16'h10 + i));
    end
    tests++; if (bus.count !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d expected 4", bus.count); end
    tests++; if (bus.alloc_ready !== 1'b0) begin fails++; $display("FAIL fill_ready: got %b expected 0", bus.alloc_ready); end
    alloc(16'h14);
    tests++; if (bus.count !== 3'd4 || bus.alloc_index !== 2'd0) begin fails++; $display("FAIL overflow_ignored: got count %0d idx %0d expected 4 0", bus.count, bus.alloc_index); end
    wb(2'd2, 16'hAAA2);
    tests++; if (bus.commit_valid !== 1'b0) begin fails++; $display("FAIL ooo_no_commit: got %b expected 0", bus.commit_valid); end
    wb(2'd0, 16'hAAA0);
    tests++; if ({bus.commit_valid, bus.commit_pc, bus.commit_result} !== {1'b1, 16'h0010, 16'hAAA0}) begin fails++; $display("FAIL commit0: got %h expected %h", {bus.commit_valid, bus.commit_pc, bus.commit_result}, {1'b1, 16'h0010, 16'hAAA0}); end
    wb(2'd1, 16'hAAA1);
    tests++; if ({bus.commit_valid, bus.commit_pc, bus.commit_result, bus.count} !== {1'b1, 16'h0011, 16'hAAA1, 3'd3}) begin fails++; $display("FAIL commit1: got %h expected %h", {bus.commit_valid, bus.commit_pc, bus.commit_result, bus.count}, {1'b1, 16'h0011, 16'hAAA1, 3'd3}); end
    wb(2'd3, 16'hAAA3);
    tests++; if ({bus.commit_valid, bus.commit_pc, bus.commit_result, bus.count} !== {1'b1, 16'h0012, 16'hAAA2, 3'd2}) begin fails++; $display("FAIL commit2: got %h expected %h", {bus.commit_valid, bus.commit_pc, bus.commit_result, bus.count}, {1'b1, 16'h0012, 16'hAAA2, 3'd2}); end
    idle();
    tests++; if ({bus.commit_valid, bus.commit_pc, bus.commit_result, bus.count} !== {1'b1, 16'h0013, 16'hAAA3, 3'd1}) begin fails++; $display("FAIL commit3: got %h expected %h", {bus.commit_valid, bus.commit_pc, bus.commit_result, bus.count}, {1'b1, 16'h0013, 16'hAAA3, 3'd1}); end
    tests++; if ({bus.commit_insn, bus.commit_has_rd, bus.commit_prd, bus.commit_old_prd} !== {16'h5A13, 1'b1, 4'h3, 4'h1}) begin fails++; $display("FAIL commit3_payload: got %h expected %h", {bus.commit_insn, bus.commit_has_rd, bus.commit_prd, bus.commit_old_prd}, {16'h5A13, 1'b1, 4'h3, 4'h1}); end
    idle();
    tests++; if ({bus.commit_valid, bus.count} !== {1'b0, 3'd0}) begin fails++; $display("FAIL drained: got %h expected 0", {bus.commit_valid, bus.count}); end
  endtask

  // Tail wraps 3 -> 0 while retirement stays in program order.
  task automatic test_wrap();
    logic [15:0] exp_pc [4] = '{16'h0022, 16'h0023, 16'h0024, 16'h0025};
    logic [1:0]  wb_seq [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 4; i++) alloc(16'(16'h20 + i));
    wb(2'd0, 16'h0);
    wb(2'd1, 16'h1);
    idle();
    tests++; if (bus.count !== 3'd2 || bus.alloc_index !== 2'd0) begin fails++; $display("FAIL wrap_tail: got count %0d idx %0d expected 2 0", bus.count, bus.alloc_index); end
    alloc(16'h24);
    tests++; if (bus.alloc_index !== 2'd1) begin fails++; $display("FAIL wrap_index: got %0d expected 1", bus.alloc_index); end
    alloc(16'h25);
    for (int i = 0; i < 4; i++) begin
      wb(wb_seq[i], 16'(i));
      tests++; if (bus.commit_valid !== 1'b1 || bus.commit_pc !== exp_pc[i]) begin fails++; $display("FAIL wrap_order%0d: got %b %h expected 1 %h", i, bus.commit_valid, bus.commit_pc, exp_pc[i]); end
    end
    idle();
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL wrap_drain: got %0d expected 0", bus.count); end
  endtask

  // Mispredict at entry 1 with entries 2,3 busy.
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(16'(16'h30 + i));
    wb(2'd0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1, 2'd1, 16'h1111, 1'b1, 16'h0200, 1'b1);
    tests++; if ({bus.flush, bus.flush_pc, bus.commit_pc, bus.count} !== {1'b1, 16'h0200, 16'h0031, 3'd3}) begin fails++; $display("FAIL flush_head: got %h expected %h", {bus.flush, bus.flush_pc, bus.commit_pc, bus.count}, {1'b1, 16'h0200, 16'h0031, 3'd3}); end
    cyc(1'b1, 16'h0077, 1'b1, 2'd2, 16'hBEEF, 1'b0, 16'h0, 1'b1);
    tests++; if ({bus.count, bus.alloc_index, bus.commit_valid, bus.flush, bus.flush_pc} !== 23'h0) begin fails++; $display("FAIL flush_clear: got %h expected 0", {bus.count, bus.alloc_index, bus.commit_valid, bus.flush, bus.flush_pc}); end
    alloc(16'h0050);
    wb(2'd0, 16'h5555);
    tests++; if ({bus.commit_valid, bus.commit_pc, bus.count} !== {1'b1, 16'h0050, 3'd1}) begin fails++; $display("FAIL flush_restart: got %h expected %h", {bus.commit_valid, bus.commit_pc, bus.count}, {1'b1, 16'h0050, 3'd1}); end
    idle();
  endtask

  // Writeback to an empty slot, and writeback/alloc with gwe=0.
  task automatic test_ignored_wb();
    do_reset();
    wb(2'd2, 16'hDEAD);
    tests++; if ({bus.commit_valid, bus.count} !== 4'h0) begin fails++; $display("FAIL wb_not_busy: got %h expected 0", {bus.commit_valid, bus.count}); end
    alloc(16'h0060);
    cyc(1'b0, 16'h0, 1'b1, 2'd0, 16'h1234, 1'b0, 16'h0, 1'b0);
    tests++; if (bus.commit_valid !== 1'b0) begin fails++; $display("FAIL wb_gwe0: got %b expected 0", bus.commit_valid); end
    cyc(1'b1, 16'h0061, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0, 1'b0);
    tests++; if (bus.count !== 3'd1 || bus.alloc_index !== 2'd1) begin fails++; $display("FAIL alloc_gwe0: got count %0d idx %0d expected 1 1", bus.count, bus.alloc_index); end
    wb(2'd0, 16'h1234);
    tests++; if ({bus.commit_valid, bus.commit_result} !== {1'b1, 16'h1234}) begin fails++; $display("FAIL wb_after_gwe: got %h expected %h", {bus.commit_valid, bus.commit_result}, {1'b1, 16'h1234}); end
    idle();
  endtask

  // Full ROB whose head is done, with a dispatch pending.
  task automatic test_full_commit();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(16'(16'h40 + i));
    wb(2'd0, 16'h4444);
`ifdef LC4_ROB_BYPASS_EN
    tests++; if (bus.alloc_ready !== 1'b1) begin fails++; $display("FAIL full_ready: got %b expected 1", bus.alloc_ready); end
    alloc(16'h0044);
    tests++; if (bus.count !== 3'd4 || bus.alloc_index !== 2'd1) begin fails++; $display("FAIL full_bypass: got count %0d idx %0d expected 4 1", bus.count, bus.alloc_index); end
`else
    tests++; if (bus.alloc_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b expected 0", bus.alloc_ready); end
    alloc(16'h0044);
    tests++; if (bus.count !== 3'd3 || bus.alloc_index !== 2'd0) begin fails++; $display("FAIL full_stall: got count %0d idx %0d expected 3 0", bus.count, bus.alloc_index); end
`endif
  endtask

  // Reset asserted between edges while full with a done head.
  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(16'(16'h80 + i));
    wb(2'd0, 16'h8888);
    tests++; if ({bus.commit_valid, bus.count} !== {1'b1, 3'd4}) begin fails++; $display("FAIL pre_async: got %h expected %h", {bus.commit_valid, bus.count}, {1'b1, 3'd4}); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if ({bus.count, bus.alloc_ready, bus.alloc_index, bus.commit_valid, bus.flush, bus.flush_pc, bus.commit_pc} !== {3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0}) begin
      fails++; $display("FAIL async_reset: got %h expected %h", {bus.count, bus.alloc_ready, bus.alloc_index, bus.commit_valid, bus.flush, bus.flush_pc, bus.commit_pc}, {3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random traffic against a program-order queue of in-flight insns.
  task automatic test_random();
    ent_t q[$];
    int   mtail;
    do_reset();
    mtail = 0;
    for (int n = 0; n < 500; n++) begin
      bit ecv, efl, erdy;
      logic av, wv, wmis, g;
      logic [15:0] pc, wres, wred;
      logic [1:0] widx;
      ent_t e;
      ecv = (q.size() > 0) && q[0].done;
      efl = ecv && q[0].misp;
`ifdef LC4_ROB_BYPASS_EN
      erdy = (q.size() < 4) || (ecv && !efl);
`else
      erdy = (q.size() < 4);
`endif
      tests++; if (bus.count !== 3'(q.size())) begin fails++; $display("FAIL rnd_count @%0d: got %0d expected %0d", n, bus.count, q.size()); end
      tests++; if ({bus.alloc_ready, bus.alloc_index} !== {erdy, 2'(mtail)}) begin fails++; $display("FAIL rnd_alloc @%0d: got %b %0d expected %b %0d", n, bus.alloc_ready, bus.alloc_index, erdy, mtail); end
      tests++; if ({bus.commit_valid, bus.flush, bus.flush_pc} !== {ecv, efl, efl ? q[0].red : 16'h0}) begin
        fails++; $display("FAIL rnd_commit @%0d: got %b %b %h expected %b %b", n, bus.commit_valid, bus.flush, bus.flush_pc, ecv, efl);
      end
      if (ecv) begin
        tests++;
        if ({bus.commit_pc, bus.commit_insn, bus.commit_has_rd, bus.commit_prd, bus.commit_old_prd, bus.commit_result} !==
            {q[0].pc, q[0].insn, q[0].has_rd, q[0].prd, q[0].oprd, q[0].res}) begin
          fails++; $display("FAIL rnd_payload @%0d: got %h expected %h", n,
            {bus.commit_pc, bus.commit_insn, bus.commit_has_rd, bus.commit_prd, bus.commit_old_prd, bus.commit_result},
            {q[0].pc, q[0].insn, q[0].has_rd, q[0].prd, q[0].oprd, q[0].res});
        end
      end
      av   = ($urandom % 4) != 0;
      pc   = 16'($urandom);
      wv   = ($urandom % 2) != 0;
      if (q.size() > 0 && ($urandom % 4) != 0) widx = q[$urandom % q.size()].idx;
      else widx = 2'($urandom % 4);
      wres = 16'($urandom);
      wmis = ($urandom % 10) == 0;
      wred = 16'($urandom);
      g    = ($urandom % 8) != 0;
      cyc(av, pc, wv, widx, wres, wmis, wred, g);
      if (g) begin
        if (efl) begin
          q.delete();
          mtail = 0;
        end else begin
          if (wv) begin
            foreach (q[k]) if (q[k].idx == widx) begin
              q[k].done = 1'b1; q[k].misp = wmis; q[k].res = wres; q[k].red = wred;
            end
          end
          if (ecv) void'(q.pop_front());
          if (av && erdy) begin
            e.idx = 2'(mtail); e.pc = pc; e.insn = pc ^ 16'h5A00; e.has_rd = pc[0];
            e.prd = pc[3:0]; e.oprd = pc[7:4]; e.done = 1'b0; e.misp = 1'b0;
            e.res = 16'h0; e.red = 16'h0;
            q.push_back(e);
            mtail = (mtail + 1) % 4;
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alloc_valid = 1'b0; bus.alloc_pc = '0; bus.alloc_insn = '0; bus.alloc_has_rd = 1'b0;
    bus.alloc_prd = '0; bus.alloc_old_prd = '0; bus.wb_valid = 1'b0; bus.wb_index = '0;
    bus.wb_result = '0; bus.wb_mispredict = 1'b0; bus.wb_pc_redirect = '0;
    test_reset();
    test_fill_inorder();
    test_wrap();
    test_flush();
    test_ignored_wb();
    test_full_commit();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
